// File: rtl/imme_pkg.sv
// Shared opcodes, field formats, error codes and FSM states for the instruction encoder.
// Also holds the immediate range-check helper.
package imme_pkg;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_LD = 3'd2,
        FMT_ST = 3'd3,
        FMT_BR = 3'd4
    } fmt_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_RANGE = 2'd1,
        ERR_ALIGN = 2'd2,
        ERR_FMT   = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    // True when imm[31:msb] are all copies of the sign bit, i.e. the value fits the field.
    function automatic logic imm_fits(input logic [31:0] imm, input int msb);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 32; b++) begin
            if (b >= msb && imm[b] != imm[31]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-bundle input, burst control and imem-write output of the instruction encoder.
// master = loader/testbench side, slave = encoder side.
interface inst_encoder_if #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 10
);
    logic              i_start;
    logic [ADDR_W-1:0] i_base;
    logic [LEN_W-1:0]  i_len;

    logic              i_valid;
    logic              o_ready;
    logic [2:0]        i_fmt;
    logic [4:0]        i_rd;
    logic [4:0]        i_rs1;
    logic [4:0]        i_rs2;
    logic [2:0]        i_funct3;
    logic [6:0]        i_funct7;
    logic [31:0]       i_imme;

    logic              o_valid;
    logic              i_ready;
    logic [31:0]       o_instruction;
    logic [ADDR_W-1:0] o_addr;
    logic              o_done;
    logic              o_err;
    logic [1:0]        o_err_code;

    modport master (
        output i_start, i_base, i_len,
        output i_valid, i_fmt, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imme,
        output i_ready,
        input  o_ready, o_valid, o_instruction, o_addr, o_done, o_err, o_err_code
    );

    modport slave (
        input  i_start, i_base, i_len,
        input  i_valid, i_fmt, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imme,
        input  i_ready,
        output o_ready, o_valid, o_instruction, o_addr, o_done, o_err, o_err_code
    );
endinterface

// File: rtl/inst_pack.sv
// Combinational RV32I field packer: builds the instruction word for one field bundle
// and reports why it was rejected, substituting a NOP for any rejected word.
module inst_pack
    import imme_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imme,
    output logic [31:0] word,
    output err_code_e   err_code
);

    logic [31:0] raw;

    // Format legality is decided first, then range, then branch alignment.
    always_comb begin
        raw      = NOP;
        err_code = ERR_NONE;
        case (fmt)
            FMT_R: begin
                raw = {funct7, rs2, rs1, funct3, rd, OP_R};
            end
            FMT_I: begin
                raw = {imme[11:0], rs1, funct3, rd, OP_I};
                if (!imm_fits(imme, 11)) err_code = ERR_RANGE;
            end
            FMT_LD: begin
                raw = {imme[11:0], rs1, funct3, rd, OP_LD};
                if (!imm_fits(imme, 11)) err_code = ERR_RANGE;
            end
            FMT_ST: begin
                raw = {imme[11:5], rs2, rs1, funct3, imme[4:0], OP_ST};
                if (!imm_fits(imme, 11)) err_code = ERR_RANGE;
            end
            FMT_BR: begin
                raw = {imme[12], imme[10:5], rs2, rs1, funct3, imme[4:1], imme[11], OP_BR};
                if (!imm_fits(imme, 12)) err_code = ERR_RANGE;
                else if (imme[0])        err_code = ERR_ALIGN;
            end
            default: begin
                err_code = ERR_FMT;
            end
        endcase
        word = (err_code == ERR_NONE) ? raw : NOP;
    end

endmodule

// File: rtl/inst_encoder.sv
// Burst loader: accepts field bundles, packs them into RV32I words and writes them
// to consecutive word addresses through a single registered output stage.
module inst_encoder
    import imme_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 10
) (
    input logic          i_clk,
    input logic          i_reset,
    inst_encoder_if.slave bus
);

    state_e            state;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  count;
    logic [ADDR_W-1:0] offset;
    logic [31:0]       pack_word;
    err_code_e         pack_err;
    logic              accept;

    inst_pack u_pack (
        .fmt      (bus.i_fmt),
        .rd       (bus.i_rd),
        .rs1      (bus.i_rs1),
        .rs2      (bus.i_rs2),
        .funct3   (bus.i_funct3),
        .funct7   (bus.i_funct7),
        .imme     (bus.i_imme),
        .word     (pack_word),
        .err_code (pack_err)
    );

    assign offset      = ADDR_W'({count, 2'b00});
    assign bus.o_ready = (state == LOAD) && (!bus.o_valid || bus.i_ready) && (count < len);
    assign accept      = bus.i_valid && bus.o_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state             <= IDLE;
            base              <= '0;
            len               <= '0;
            count             <= '0;
            bus.o_valid       <= 1'b0;
            bus.o_instruction <= '0;
            bus.o_addr        <= '0;
            bus.o_done        <= 1'b0;
            bus.o_err         <= 1'b0;
            bus.o_err_code    <= ERR_NONE;
        end else begin
            bus.o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        base           <= bus.i_base & ~ADDR_W'(3);
                        len            <= bus.i_len;
                        count          <= '0;
                        bus.o_err      <= 1'b0;
                        bus.o_err_code <= ERR_NONE;
                        if (bus.i_len == '0) begin
                            state      <= DONE;
                            bus.o_done <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    // A stalled word stays put; an accept may overwrite only a word being drained.
                    if (accept) begin
                        bus.o_valid       <= 1'b1;
                        bus.o_instruction <= pack_word;
                        bus.o_addr        <= base + offset;
                        count             <= count + 1'b1;
                        if (pack_err != ERR_NONE) begin
                            bus.o_err <= 1'b1;
                            if (bus.o_err_code == ERR_NONE) bus.o_err_code <= pack_err;
                        end
                    end else if (bus.o_valid && bus.i_ready) begin
                        bus.o_valid <= 1'b0;
                    end
                    if (!accept && count == len && (!bus.o_valid || bus.i_ready)) begin
                        state      <= DONE;
                        bus.o_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
